// File: rtl/rat_flags_pkg.sv
// Shared types for the ALU flag unit:
// branch condition codes and the {C,Z} flag pair.
package rat_flags_pkg;

  typedef enum logic [2:0] {
    BR_ALWAYS = 3'd0,
    BR_CS     = 3'd1,
    BR_CC     = 3'd2,
    BR_EQ     = 3'd3,
    BR_NE     = 3'd4
  } br_cond_t;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of saved {C,Z} pairs for nested interrupts.
// Push/pop are ignored when full/empty; depth never wraps.
module flag_shadow_stack
  import rat_flags_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        top,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  flags_t        mem_q [DEPTH];
  flags_t        mem_d [DEPTH];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  // Top-of-stack read and next stack contents/depth.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    top     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i + 1) == depth_q) top = mem_q[i];
    end
    if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (DW'(i) == depth_q) mem_d[i] = din;
      end
      depth_d = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Stack storage and depth register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      depth_q <= '0;
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/alu_flags_unit.sv
// C/Z flag registers with SEC/CLC, shadow save/restore,
// sticky stack errors and branch condition decode.
module alu_flags_unit
  import rat_flags_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ALU_C,
  input  logic          ALU_Z,
  input  logic          FLG_C_LD,
  input  logic          FLG_Z_LD,
  input  logic          FLG_C_SET,
  input  logic          FLG_C_CLR,
  input  logic          FLG_SAVE,
  input  logic          FLG_RESTORE,
  input  logic [2:0]    BR_COND,
  output logic          C_FLAG,
  output logic          Z_FLAG,
  output logic          ALU_CIN,
  output logic          BR_TAKE,
  output logic [DW-1:0] SHAD_DEPTH,
  output logic          SHAD_OVF,
  output logic          SHAD_UNF
);

  flags_t flags_q;
  flags_t flags_d;
  flags_t top;
  logic   ovf_q;
  logic   ovf_d;
  logic   unf_q;
  logic   unf_d;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;

  // A save/restore collision is an error, never a stack op.
  assign push = FLG_SAVE && !FLG_RESTORE;
  assign pop  = FLG_RESTORE && !FLG_SAVE;

  flag_shadow_stack #(.DEPTH(DEPTH)) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (flags_q),
    .top   (top),
    .full  (full),
    .empty (empty),
    .depth (SHAD_DEPTH)
  );

  // Flag next-value priority and sticky error capture.
  always_comb begin
    flags_d = flags_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (pop && !empty) begin
      flags_d = top;
    end else begin
      if (FLG_C_SET)      flags_d.c = 1'b1;
      else if (FLG_C_CLR) flags_d.c = 1'b0;
      else if (FLG_C_LD)  flags_d.c = ALU_C;
      if (FLG_Z_LD)       flags_d.z = ALU_Z;
    end
    if (FLG_SAVE && (FLG_RESTORE || full)) ovf_d = 1'b1;
    if (FLG_RESTORE && (FLG_SAVE || empty)) unf_d = 1'b1;
  end

  // Flag and error registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Branch decision from registered flags.
  always_comb begin
    BR_TAKE = 1'b0;
    case (br_cond_t'(BR_COND))
      BR_ALWAYS: BR_TAKE = 1'b1;
      BR_CS:     BR_TAKE = flags_q.c;
      BR_CC:     BR_TAKE = !flags_q.c;
      BR_EQ:     BR_TAKE = flags_q.z;
      BR_NE:     BR_TAKE = !flags_q.z;
      default:   BR_TAKE = 1'b0;
    endcase
  end

  assign C_FLAG   = flags_q.c;
  assign Z_FLAG   = flags_q.z;
  assign ALU_CIN  = flags_q.c;
  assign SHAD_OVF = ovf_q;
  assign SHAD_UNF = unf_q;

endmodule
